clk_rst_sequencer: RTL
======================

Name: clk_rst_sequencer

Overview:
- Power-up and recovery sequencer for the clocking block.
- Runs on the free-running 50 MHz board clock.
- Resets the PLL, waits for a debounced lock, then releases resets in order: IO/SERDES domain (clk_rxio/clk_txio) first, then the system domain (rst_sys_n).
- On lock loss it re-asserts all resets and retries; after repeated failures it parks in a fault state.

Parameters:
- PLL_RST_CYC, 16: cycles pll_rst is held high per attempt (min 1).
- LOCK_TIMEOUT, 50000: cycles to wait for lock before retrying (1 ms).
- STABLE_CYC, 256: consecutive cycles lock must stay high before release.
- IO_DLY, 32: cycles between io_rst release and rst_sys_n release.
- MAX_RETRY, 7: failed attempts tolerated before FAULT.
- CNT_W, 17: shared down-counter width; must hold max(all cycle parameters).

Ports:
- clk_50M  in  1  free-running 50 MHz board clock; only clock of the block.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  raw PLL lock, asynchronous to clk_50M.
- pll_rst  out  1  active-high PLL reset.
- io_rst  out  1  active-high reset for SERDES/BUFPLL, i.e. the rx/tx IO clock domain.
- rst_sys_n  out  1  active-low system reset.
- ready  out  1  high in RUN only.
- fault  out  1  high in FAULT only.
- retry_cnt  out  8  saturating count of failed or lost-lock attempts.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset is one clock only; there is no asynchronous reset anywhere. Synchronous rst=1 gives:
  - state=PLL_RST, counter=PLL_RST_CYC-1.
  - pll_rst=1, io_rst=1, rst_sys_n=0, ready=0, fault=0, retry_cnt=0.
- pll_locked passes through a 2-flop synchronizer; lk is the synchronized value. The synchronizer flops reset to 0.
- Reset behaviour overall:
  - rst applies mid-operation from any state, including FAULT, and takes effect on the next edge.
  - rst is the only exit from FAULT.
- States, with encoding in state_o:
  - PLL_RST(0):
    - pll_rst=1; the counter counts down.
    - At 0: load LOCK_TIMEOUT-1, go to WAIT_LOCK.
  - WAIT_LOCK(1):
    - pll_rst=0.
    - If lk=1: load STABLE_CYC-1, go to STABLE.
    - Else if counter=0: timeout failure.
    - Else decrement.
  - STABLE(2):
    - If lk=0: glitch; reload LOCK_TIMEOUT-1, return to WAIT_LOCK. This is not a failure.
    - Else at counter=0: go to IO_REL.
  - IO_REL(3):
    - io_rst=0; load IO_DLY-1 on entry.
    - If lk drops: failure.
    - At counter=0: go to RUN.
  - RUN(4):
    - rst_sys_n=1, ready=1.
    - If lk=0: failure.
  - FAULT(5):
    - pll_rst=1, io_rst=1, rst_sys_n=0, fault=1.
    - Held until rst.
- Failure action, in the same cycle as detection:
  - retry_cnt increments, saturating at 255.
  - If retry_cnt (pre-increment) >= MAX_RETRY: go to FAULT.
  - Else: load PLL_RST_CYC-1, go to PLL_RST.
- Output registering and timing:
  - All outputs are registered and decoded from the next state.
  - Lock loss to io_rst=1 and rst_sys_n=0 takes 1 cycle after lk falls, i.e. 3 cycles after raw pll_locked falls.
- Reset ordering invariants:
  - rst_sys_n=1 implies io_rst=0.
  - io_rst=0 implies pll_rst=0.
  - A bench assertion checks both every cycle.
- Boundary conditions:
  - lk rising on the timeout cycle (counter=0): lock wins and the block goes to STABLE.
  - Any parameter =1 gives a single-cycle state.

Decomposition:
- Package clk_rst_pkg holds:
  - the state enum with fixed encodings 0..5;
  - default timing constants;
  - a CNT_W helper, clog2 of the max parameter.
- One sub-module, sync_2ff: a generic 1-bit two-flop synchronizer with synchronous active-high reset. It is reused elsewhere for async status inputs.
- The FSM and down-counter stay in clk_rst_sequencer.

Test Plan:
Bench uses PLL_RST_CYC=4, LOCK_TIMEOUT=20, STABLE_CYC=8, IO_DLY=5, MAX_RETRY=2.
- Nominal bring-up:
  - Stimulus: rst for 3 cycles; pll_locked rises 10 cycles after pll_rst falls and stays high.
  - Required: pll_rst high exactly 4 cycles; io_rst falls 2+8 cycles after the raw rise; rst_sys_n rises 5 cycles later; ready=1; retry_cnt=0.
- Timeout retry:
  - Stimulus: pll_locked held 0.
  - Required: after 4+20 cycles, pll_rst re-asserts with retry_cnt=1.
- Fault on repeated failure:
  - Stimulus: pll_locked held 0.
  - Required: after the third timeout, state_o=5, fault=1, retry_cnt=3; outputs stay frozen 1000 cycles; rst returns to PLL_RST with retry_cnt=0.
- Glitch during STABLE:
  - Stimulus: pll_locked low 1 cycle, mid-STABLE.
  - Required: returns to WAIT_LOCK; retry_cnt unchanged; full STABLE_CYC re-counted before io_rst falls.
- Lock loss in RUN:
  - Stimulus: drop pll_locked for 50 cycles.
  - Required: rst_sys_n=0 and io_rst=1 exactly 3 cycles after the drop; retry_cnt=1; full sequence re-runs to ready.
- Reset mid-sequence:
  - Stimulus: assert rst during IO_REL.
  - Required: next cycle all outputs at reset values; the ordering assertion never fires in any test.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared types and default timing for the clock/reset sequencer.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_IO_REL    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam int unsigned DEF_PLL_RST_CYC  = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT = 50000;
  localparam int unsigned DEF_STABLE_CYC   = 256;
  localparam int unsigned DEF_IO_DLY       = 32;
  localparam int unsigned DEF_MAX_RETRY    = 7;

  // Counter width from the largest cycle parameter, with one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

  localparam int unsigned DEF_CNT_W =
    cnt_width(DEF_PLL_RST_CYC, DEF_LOCK_TIMEOUT, DEF_STABLE_CYC, DEF_IO_DLY);

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clk_rst_sequencer.sv
// Power-up/recovery sequencer: PLL reset, lock debounce, ordered IO then system release.
module clk_rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC  = DEF_PLL_RST_CYC,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYC   = DEF_STABLE_CYC,
  parameter int unsigned IO_DLY       = DEF_IO_DLY,
  parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       io_rst,
  output logic       rst_sys_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_cnt,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] L_PLL = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] L_TO  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_ST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] L_IO  = CNT_W'(IO_DLY - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_retry, w_retry_nxt;
  logic             r_pll_rst, r_io_rst, r_rst_sys_n, r_ready, r_fault;
  logic             w_pll_rst, w_io_rst, w_rst_sys_n, w_ready, w_fault;
  logic             w_lk, w_fail, w_zero;

  sync_2ff u_lock_sync (
    .i_clk (clk_50M),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_lk)
  );

  assign w_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_fail      = 1'b0;
    case (r_state)
      ST_PLL_RST: begin
        if (w_zero) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = L_TO;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      // Lock is checked before the timeout so a lock on the last cycle wins.
      ST_WAIT_LOCK: begin
        if (w_lk) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = L_ST;
        end else if (w_zero) begin
          w_fail = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!w_lk) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = L_TO;
        end else if (w_zero) begin
          w_state_nxt = ST_IO_REL;
          w_cnt_nxt   = L_IO;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_IO_REL: begin
        if (!w_lk) begin
          w_fail = 1'b1;
        end else if (w_zero) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!w_lk) w_fail = 1'b1;
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_PLL_RST;
        w_cnt_nxt   = L_PLL;
      end
    endcase

    if (w_fail) begin
      if (r_retry != 8'hFF) w_retry_nxt = r_retry + 8'd1;
      if (32'(r_retry) >= MAX_RETRY) begin
        w_state_nxt = ST_FAULT;
      end else begin
        w_state_nxt = ST_PLL_RST;
        w_cnt_nxt   = L_PLL;
      end
    end

    w_pll_rst   = (w_state_nxt == ST_PLL_RST) || (w_state_nxt == ST_FAULT);
    w_io_rst    = (w_state_nxt != ST_IO_REL) && (w_state_nxt != ST_RUN);
    w_rst_sys_n = (w_state_nxt == ST_RUN);
    w_ready     = (w_state_nxt == ST_RUN);
    w_fault     = (w_state_nxt == ST_FAULT);
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= L_PLL;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_io_rst    <= 1'b1;
      r_rst_sys_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_rst   <= w_pll_rst;
      r_io_rst    <= w_io_rst;
      r_rst_sys_n <= w_rst_sys_n;
      r_ready     <= w_ready;
      r_fault     <= w_fault;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign io_rst    = r_io_rst;
  assign rst_sys_n = r_rst_sys_n;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;
  assign state_o   = r_state;

endmodule
